// File: rtl/array_port_arbiter_if.sv
// Handshake bundle for array_port_arbiter: per-requester valid/ready/data/last
// arrays on the input side and a single valid/ready beat channel on the output.
interface array_port_arbiter_if #(
   parameter int NUM_REQ = 6,
   parameter int DATA_W  = 8,
   parameter int SRC_W   = $clog2(NUM_REQ)
);
   logic              req_valid [NUM_REQ];
   logic [DATA_W-1:0] req_data  [NUM_REQ];
   logic              req_last  [NUM_REQ];
   logic              req_ready [NUM_REQ];
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [SRC_W-1:0]  out_src;
   logic              out_ready;

   modport master (
      output req_valid, req_data, req_last, out_ready,
      input  req_ready, out_valid, out_data, out_src
   );

   modport slave (
      input  req_valid, req_data, req_last, out_ready,
      output req_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/array_port_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters into one registered
// valid/ready output stage, with an accepted-beat counter.
// Ports: clk, rst_n (async active-low); bus (slave modport: req_valid/
// req_data/req_last/req_ready arrays in, out_valid/out_data/out_src/out_ready
// out); xfer_count = beats accepted into the output register.
// Optional macro ARB_BURST_LOCK_EN: a requester keeps the grant from the
// first beat of a burst until its req_last beat is accepted.
module array_port_arbiter #(
   parameter int NUM_REQ = 6,
   parameter int DATA_W  = 8,
   parameter int SRC_W   = $clog2(NUM_REQ),
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   array_port_arbiter_if.slave bus,
   output logic [CNT_W-1:0]   xfer_count
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [SRC_W-1:0]  out_src_q, out_src_d;
   logic [SRC_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              slot_free;
   logic              win_found;
   logic              grant;
   logic [SRC_W-1:0]  win_idx;
   logic [SRC_W:0]    scan_c;

`ifdef ARB_BURST_LOCK_EN
   typedef enum logic {UNLOCKED, LOCKED} lock_e;
   lock_e            lock_q, lock_d;
   logic [SRC_W-1:0] owner_q, owner_d;
`else
   logic [NUM_REQ-1:0] unused_last;
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unused
      assign unused_last[g] = bus.req_last[g];
   end
`endif

   assign slot_free = !out_valid_q || bus.out_ready;

   // Cyclic search starting just after the last winner. scan_c is one bit
   // wider than an index so ptr+k never overflows before the wrap.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_c    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_c = {1'b0, ptr_q} + (SRC_W+1)'(k);
         if (scan_c >= (SRC_W+1)'(NUM_REQ)) begin
            scan_c = scan_c - (SRC_W+1)'(NUM_REQ);
         end
         if (!win_found && bus.req_valid[scan_c[SRC_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_c[SRC_W-1:0];
         end
      end
`ifdef ARB_BURST_LOCK_EN
      // A locked burst owns the channel even while its valid is low.
      if (lock_q == LOCKED) begin
         win_idx   = owner_q;
         win_found = bus.req_valid[owner_q];
      end
`endif
   end

   assign grant = slot_free && win_found;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_ready[i] = grant && (win_idx == SRC_W'(i));
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      if (grant) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.req_data[win_idx];
         out_src_d   = win_idx;
         ptr_d       = win_idx;
         cnt_d       = cnt_q + 1'b1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

`ifdef ARB_BURST_LOCK_EN
   always_comb begin
      lock_d  = lock_q;
      owner_d = owner_q;
      unique case (lock_q)
         UNLOCKED: begin
            if (grant && !bus.req_last[win_idx]) begin
               lock_d  = LOCKED;
               owner_d = win_idx;
            end
         end
         LOCKED: begin
            if (grant && bus.req_last[win_idx]) begin
               lock_d = UNLOCKED;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q  <= UNLOCKED;
         owner_q <= '0;
      end else begin
         lock_q  <= lock_d;
         owner_q <= owner_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr_q       <= SRC_W'(NUM_REQ-1);
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;
   assign xfer_count    = cnt_q;

endmodule

// File: tb/tb_array_port_arbiter.sv
// Scoreboard bench for array_port_arbiter: random and directed traffic,
// reference model predicts grants, beats and the transfer count.
module tb_array_port_arbiter;

   localparam int N  = 6;
   localparam int DW = 8;
   localparam int SW = 3;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] xfer_count;

   array_port_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .SRC_W(SW)) bus ();

   array_port_arbiter #(
      .NUM_REQ(N), .DATA_W(DW), .SRC_W(SW), .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave),
      .xfer_count(xfer_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit run      = 1'b0;

   int m_ptr;
   int m_cnt;
   int m_owner;
   bit m_occ;
   bit m_lock;

   typedef struct {
      logic [DW-1:0] d;
      int            s;
   } beat_t;
   beat_t q[$];

   function automatic void chk(string name, logic [31:0] act,
                               logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic model_reset();
      q.delete();
      m_ptr   = N-1;
      m_cnt   = 0;
      m_occ   = 1'b0;
      m_lock  = 1'b0;
      m_owner = 0;
   endtask

   task automatic drive(bit [N-1:0] v, bit [N-1:0] l, bit rdy);
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i] = v[i];
         bus.req_last[i]  = l[i];
         bus.req_data[i]  = DW'($urandom);
      end
      bus.out_ready = rdy;
   endtask

   // Reference model: predicts req_ready, pushes accepted beats.
   always @(negedge clk) begin : model
      int w;
      bit have;
      bit slot;
      bit last;
      #2;
      if (run) begin
         slot = !m_occ || bus.out_ready;
         have = 1'b0;
         w    = 0;
`ifdef ARB_BURST_LOCK_EN
         if (m_lock) begin
            have = bus.req_valid[m_owner];
            w    = m_owner;
         end else
`endif
         for (int k = 1; k <= N; k++) begin
            if (!have && bus.req_valid[(m_ptr + k) % N]) begin
               have = 1'b1;
               w    = (m_ptr + k) % N;
            end
         end
         for (int i = 0; i < N; i++) begin
            chk($sformatf("req_ready[%0d]", i), bus.req_ready[i],
                have && slot && (i == w));
         end
         if (have && slot) begin
            q.push_back('{d: bus.req_data[w], s: w});
            m_ptr = w;
            m_cnt = (m_cnt + 1) % 65536;
            m_occ = 1'b1;
            last  = bus.req_last[w];
`ifdef ARB_BURST_LOCK_EN
            if (!m_lock && !last) begin
               m_lock  = 1'b1;
               m_owner = w;
            end else if (m_lock && last) begin
               m_lock = 1'b0;
            end
`endif
         end else if (bus.out_ready) begin
            m_occ = 1'b0;
         end
      end
   end

   // Monitor: compares the presented beat with the scoreboard head.
   always @(negedge clk) begin : monitor
      #1;
      if (run) begin
         chk("out_valid", bus.out_valid, m_occ);
         chk("xfer_count", xfer_count, m_cnt);
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL beat_unexpected: src %0d data %0h",
                        bus.out_src, bus.out_data);
            end else begin
               chk("out_data", bus.out_data, q[0].d);
               chk("out_src", bus.out_src, q[0].s);
               if (bus.out_ready) begin
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      int guard;
      rst_n = 1'b0;
      model_reset();
      drive('0, '1, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_src", bus.out_src, 0);
      chk("rst_xfer_count", xfer_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b1;

      // single request from requester 2
      @(negedge clk);
      drive(6'b000100, '1, 1'b1);
      bus.req_data[2] = 8'hA5;
      @(negedge clk);
      drive('0, '1, 1'b1);

      // fairness sweep
      repeat (12) begin
         @(negedge clk);
         drive('1, '1, 1'b1);
      end

      // backpressure
      repeat (3) begin
         @(negedge clk);
         drive('1, '1, 1'b0);
      end
      @(negedge clk);
      drive('1, '1, 1'b1);

      // random traffic
      repeat (3000) begin
         @(negedge clk);
         drive(N'($urandom), N'($urandom), $urandom_range(0, 3) != 0);
      end

      // asynchronous reset while a beat is held
      @(negedge clk);
      drive('1, '1, 1'b0);
      for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
      @(negedge clk);
      run = 1'b0;
      chk("pre_reset_valid", bus.out_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", bus.out_valid, 0);
      chk("async_xfer_count", xfer_count, 0);
      chk("async_out_src", bus.out_src, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b1;
      drive('1, '1, 1'b1);
      @(negedge clk);
      drive('0, '1, 1'b1);

`ifdef ARB_BURST_LOCK_EN
      // requester 3 burst of three beats while requester 1 waits
      @(negedge clk);
      drive(6'b001000, 6'b000000, 1'b1);
      @(negedge clk);
      drive(6'b001010, 6'b000010, 1'b1);
      @(negedge clk);
      drive(6'b001010, 6'b001010, 1'b1);
      @(negedge clk);
      drive(6'b000010, '1, 1'b1);
      @(negedge clk);
      drive('0, '1, 1'b1);
`endif

      // stream until the counter wraps
      guard = 0;
      while (m_cnt != 16'hFFFF && guard < 70000) begin
         @(negedge clk);
         drive('1, '1, 1'b1);
         guard++;
      end
      if (guard >= 70000) begin
         n_checks++;
         n_fail++;
         $display("FAIL wrap_timeout: count %0h expected ffff", m_cnt);
      end
      @(negedge clk);
      drive('0, '1, 1'b1);
      #1;
      chk("xfer_count_wrap", xfer_count, 0);

      repeat (3) begin
         @(negedge clk);
         drive('0, '1, 1'b1);
      end
      #3;
      chk("scoreboard_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
